// File: rtl/block_dispatch_sequencer.sv
// Per-sample instruction sequencer: fetches one instruction per running block and hands it to decode.
// Optional SEQ_SKIP_NOP_EN: all-zero instruction words are dropped instead of presented.
module block_dispatch_sequencer #(
  parameter int unsigned data_width  = 16,
  parameter int unsigned n_blocks    = 256,
  parameter int unsigned instr_width = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         sample_tick,
  input  logic [$clog2(n_blocks)-1:0]  n_blocks_running,
  output logic [$clog2(n_blocks)-1:0]  instr_read_addr,
  input  logic [instr_width-1:0]       instr_read_val,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [instr_width-1:0]       instr_out,
  output logic [$clog2(n_blocks)-1:0]  block_out,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         overrun,
  input  logic                         clear_overrun
);

  localparam int unsigned IdxW = $clog2(n_blocks);

  if (n_blocks < 2 || data_width == 0) begin : g_param_check
    $error("block_dispatch_sequencer: n_blocks must be >= 2 and data_width nonzero");
  end

  typedef enum logic [1:0] {StIdle, StFetch, StWait, StPresent} state_e;

  state_e                 state_q, state_d;
  logic [IdxW-1:0]        n_last_q, n_last_d;
  logic [IdxW-1:0]        block_ctr_q, block_ctr_d;
  logic [IdxW-1:0]        addr_q, addr_d;
  logic [IdxW-1:0]        block_out_q, block_out_d;
  logic [instr_width-1:0] instr_q, instr_d;
  logic                   valid_q, valid_d;
  logic                   frame_done_q, frame_done_d;
  logic                   overrun_q, overrun_d;

  logic last_blk, handshake, skip_nop, advance;

`ifdef SEQ_SKIP_NOP_EN
  assign skip_nop = (instr_read_val == '0);
`else
  assign skip_nop = 1'b0;
`endif

  assign last_blk  = (block_ctr_q == n_last_q);
  assign handshake = valid_q && out_ready;
  // A block is finished either by its handshake or by being skipped as a NOP.
  assign advance   = ((state_q == StPresent) && handshake) || ((state_q == StWait) && skip_nop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (enable) begin
      unique case (state_q)
        StIdle:    if (sample_tick && (n_blocks_running != '0)) state_d = StFetch;
        StFetch:   state_d = StWait;
        StWait:    state_d = skip_nop ? (last_blk ? StIdle : StFetch) : StPresent;
        StPresent: if (handshake) state_d = last_blk ? StIdle : StFetch;
        default:   state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    n_last_d     = n_last_q;
    block_ctr_d  = block_ctr_q;
    addr_d       = addr_q;
    block_out_d  = block_out_q;
    instr_d      = instr_q;
    valid_d      = valid_q;
    frame_done_d = 1'b0;
    overrun_d    = overrun_q;
    if (enable) begin
      if (sample_tick && (state_q != StIdle)) begin
        overrun_d = 1'b1;
      end else if (clear_overrun) begin
        overrun_d = 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (sample_tick) begin
            if (n_blocks_running == '0) begin
              frame_done_d = 1'b1;
            end else begin
              n_last_d    = n_blocks_running - 1'b1;
              block_ctr_d = '0;
              addr_d      = '0;
            end
          end
        end
        StWait: begin
          if (!skip_nop) begin
            instr_d     = instr_read_val;
            block_out_d = block_ctr_q;
            valid_d     = 1'b1;
          end
        end
        StPresent: if (handshake) valid_d = 1'b0;
        default: ;
      endcase
      if (advance) begin
        if (last_blk) begin
          frame_done_d = 1'b1;
        end else begin
          block_ctr_d = block_ctr_q + 1'b1;
          addr_d      = block_ctr_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_last_q     <= '0;
      block_ctr_q  <= '0;
      addr_q       <= '0;
      block_out_q  <= '0;
      instr_q      <= '0;
      valid_q      <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      n_last_q     <= n_last_d;
      block_ctr_q  <= block_ctr_d;
      addr_q       <= addr_d;
      block_out_q  <= block_out_d;
      instr_q      <= instr_d;
      valid_q      <= valid_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

  always_comb begin
    busy            = (state_q != StIdle);
    out_valid       = valid_q;
    instr_out       = instr_q;
    block_out       = block_out_q;
    instr_read_addr = addr_q;
    overrun         = overrun_q;
    frame_done      = frame_done_q && enable;
  end

endmodule

// File: tb/tb_block_dispatch_sequencer.sv
// Self-checking bench for block_dispatch_sequencer: directed timing scenarios plus randomized
// frames scored against a per-frame list of expected (block, word) transfers.
module tb_block_dispatch_sequencer;
  localparam int unsigned NB = 256;
  localparam int unsigned IW = 32;
  localparam int unsigned AW = $clog2(NB);

  logic          clk = 1'b0;
  logic          reset, enable, sample_tick, out_ready, clear_overrun;
  logic [AW-1:0] n_blocks_running, instr_read_addr, block_out;
  logic [IW-1:0] instr_read_val, instr_out;
  logic          out_valid, busy, frame_done, overrun;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int tc, fd_cnt, fd_cyc, valid_cycles;

  logic [IW-1:0]    mem [NB];
  logic [AW+IW-1:0] got_q[$];
  logic [AW+IW-1:0] exp_q[$];
  int               hs_cyc[$];

  block_dispatch_sequencer #(
    .data_width (16),
    .n_blocks   (NB),
    .instr_width(IW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .sample_tick     (sample_tick),
    .n_blocks_running(n_blocks_running),
    .instr_read_addr (instr_read_addr),
    .instr_read_val  (instr_read_val),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .instr_out       (instr_out),
    .block_out       (block_out),
    .busy            (busy),
    .frame_done      (frame_done),
    .overrun         (overrun),
    .clear_overrun   (clear_overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) instr_read_val <= mem[instr_read_addr];

  // Observe mid-cycle; a handshake seen here completes on the next rising edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (enable && out_valid && out_ready) begin
        got_q.push_back({block_out, instr_out});
        hs_cyc.push_back(cyc);
      end
      if (frame_done) begin
        fd_cnt++;
        fd_cyc = cyc;
      end
      if (out_valid) valid_cycles++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected transfers of a frame: blocks 0..n-1 in order, NOPs dropped when skipping is built in.
  task automatic build_exp(input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
`ifdef SEQ_SKIP_NOP_EN
      if (mem[i] == '0) continue;
`endif
      exp_q.push_back({AW'(i), mem[i]});
    end
  endtask

  task automatic start_frame(input int n);
    got_q.delete();
    hs_cyc.delete();
    fd_cnt = 0;
    valid_cycles = 0;
    n_blocks_running = AW'(n);
    sample_tick = 1'b1;
    tc = cyc;
    step();
    sample_tick = 1'b0;
  endtask

  task automatic finish_frame(input int budget);
    int i = 0;
    while (busy && i < budget) begin
      step();
      i++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout: busy=%b after %0d cycles, required 0", busy, budget);
    end
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++;
    if ({out_valid, busy, frame_done, overrun, instr_read_addr, instr_out, block_out} !== '0) begin
      errors++;
      $display("FAIL reset_state: got v=%b b=%b fd=%b ov=%b a=%h i=%h blk=%h, required all 0",
               out_valid, busy, frame_done, overrun, instr_read_addr, instr_out, block_out);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic();
    for (int i = 0; i < 3; i++) mem[i] = 32'h100 + 32'(i);
    out_ready = 1'b1;
    build_exp(3);
    start_frame(3);
    finish_frame(40);
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL basic_count: got %0d transfers, required %0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL basic_xfer%0d: got %h, required %h", i, got_q[i], exp_q[i]);
        end
      end
    end
    foreach (hs_cyc[i]) begin
      checks++;
      if (hs_cyc[i] !== tc + 3 + 3 * i) begin
        errors++;
        $display("FAIL basic_timing%0d: got cycle %0d, required %0d", i, hs_cyc[i] - tc, 3 + 3 * i);
      end
    end
    checks++;
    if (fd_cnt !== 1 || fd_cyc !== tc + 10) begin
      errors++;
      $display("FAIL basic_done: got %0d pulses at +%0d, required 1 at +10", fd_cnt, fd_cyc - tc);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle: got busy=%b, required 0", busy);
    end
  endtask

  task automatic test_stall();
    bit stalled = 1'b0;
    int exp_hs[3];
    out_ready = 1'b1;
    build_exp(3);
    start_frame(3);
    exp_hs = '{tc + 3, tc + 11, tc + 14};
    for (int i = 0; i < 40 && busy; i++) begin
      if (!stalled && out_valid && block_out == AW'(1)) begin
        stalled = 1'b1;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          checks++;
          if (out_valid !== 1'b1 || instr_out !== 32'h101 || block_out !== AW'(1)) begin
            errors++;
            $display("FAIL stall_hold%0d: got v=%b i=%h blk=%h, required 1/00000101/01",
                     k, out_valid, instr_out, block_out);
          end
          step();
        end
        out_ready = 1'b1;
      end
      step();
    end
    finish_frame(10);
    checks++;
    if (stalled !== 1'b1 || hs_cyc.size() !== 3) begin
      errors++;
      $display("FAIL stall_seen: got stalled=%b transfers=%0d, required 1/3", stalled, hs_cyc.size());
    end else begin
      foreach (exp_hs[i]) begin
        checks++;
        if (hs_cyc[i] !== exp_hs[i] || got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL stall_xfer%0d: got %h at +%0d, required %h at +%0d",
                   i, got_q[i], hs_cyc[i] - tc, exp_q[i], exp_hs[i] - tc);
        end
      end
    end
    checks++;
    if (fd_cyc !== tc + 15) begin
      errors++;
      $display("FAIL stall_done: got frame_done at +%0d, required +15", fd_cyc - tc);
    end
  endtask

  task automatic test_overrun();
    out_ready = 1'b1;
    build_exp(3);
    start_frame(3);
    for (int i = 0; i < 20 && !(out_valid && block_out == AW'(1)); i++) step();
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set: got %b, required 1", overrun);
    end
    finish_frame(40);
    checks++;
    if (got_q.size() !== 3 || got_q[2] !== exp_q[2] || fd_cnt !== 1) begin
      errors++;
      $display("FAIL overrun_frame: got %0d transfers, %0d done pulses, required 3/1",
               got_q.size(), fd_cnt);
    end
    clear_overrun = 1'b1;
    step();
    clear_overrun = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear: got %b, required 0", overrun);
    end
    start_frame(3);
    sample_tick = 1'b1;
    clear_overrun = 1'b1;
    step();
    sample_tick = 1'b0;
    clear_overrun = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set_wins: got %b, required 1", overrun);
    end
    finish_frame(40);
    clear_overrun = 1'b1;
    step();
    clear_overrun = 1'b0;
  endtask

  task automatic test_tick_on_last();
    out_ready = 1'b1;
    start_frame(1);
    step();
    step();
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    checks++;
    if (overrun !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL last_tick: got overrun=%b busy=%b, required 1/0", overrun, busy);
    end
    step();
    step();
    checks++;
    if (busy !== 1'b0 || got_q.size() !== 1 || fd_cnt !== 1) begin
      errors++;
      $display("FAIL last_tick_nostart: got busy=%b transfers=%0d done=%0d, required 0/1/1",
               busy, got_q.size(), fd_cnt);
    end
    clear_overrun = 1'b1;
    step();
    clear_overrun = 1'b0;
  endtask

  task automatic test_zero_and_midchange();
    out_ready = 1'b1;
    start_frame(0);
    finish_frame(10);
    step();
    checks++;
    if (valid_cycles !== 0 || fd_cnt !== 1 || got_q.size() !== 0) begin
      errors++;
      $display("FAIL zero_frame: got valid=%0d done=%0d transfers=%0d, required 0/1/0",
               valid_cycles, fd_cnt, got_q.size());
    end
    build_exp(2);
    start_frame(2);
    n_blocks_running = AW'(5);
    finish_frame(40);
    checks++;
    if (got_q.size() !== exp_q.size() || got_q[1] !== exp_q[1]) begin
      errors++;
      $display("FAIL midchange: got %0d transfers, required %0d", got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    start_frame(3);
    for (int i = 0; i < 20 && !(out_valid && block_out == AW'(1)); i++) step();
    out_ready = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if ({out_valid, busy, block_out, instr_out, instr_read_addr} !== '0) begin
      errors++;
      $display("FAIL reset_async: got v=%b busy=%b blk=%h i=%h a=%h, required all 0",
               out_valid, busy, block_out, instr_out, instr_read_addr);
    end
    step();
    reset = 1'b0;
    out_ready = 1'b1;
    build_exp(3);
    start_frame(3);
    finish_frame(40);
    checks++;
    if (got_q.size() !== 3 || got_q[0] !== exp_q[0] || got_q[2] !== exp_q[2]) begin
      errors++;
      $display("FAIL reset_restart: got %0d transfers first=%h, required 3 first=%h",
               got_q.size(), got_q.size() > 0 ? got_q[0] : '0, exp_q[0]);
    end
  endtask

  task automatic test_enable();
    logic [1+IW+AW+AW:0] snap;
    out_ready = 1'b1;
    build_exp(3);
    start_frame(3);
    for (int i = 0; i < 20 && !out_valid; i++) step();
    snap = {out_valid, instr_out, block_out, instr_read_addr, busy};
    enable = 1'b0;
    sample_tick = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if ({out_valid, instr_out, block_out, instr_read_addr, busy} !== snap || frame_done !== 1'b0) begin
        errors++;
        $display("FAIL enable_hold%0d: got %h fd=%b, required %h fd=0",
                 k, {out_valid, instr_out, block_out, instr_read_addr, busy}, frame_done, snap);
      end
    end
    enable = 1'b1;
    sample_tick = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL enable_no_overrun: got %b, required 0", overrun);
    end
    finish_frame(40);
    checks++;
    if (got_q.size() !== 3 || got_q[1] !== exp_q[1]) begin
      errors++;
      $display("FAIL enable_frame: got %0d transfers, required 3", got_q.size());
    end
    start_frame(0);
    enable = 1'b0;
    #1;
    checks++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL enable_gates_done: got %b, required 0", frame_done);
    end
    enable = 1'b1;
    step();
  endtask

  task automatic test_random();
    int n;
    for (int f = 0; f < 8; f++) begin
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) mem[i] = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      build_exp(n);
      start_frame(n);
      for (int c = 0; c < 400 && busy; c++) begin
        out_ready = ($urandom_range(0, 3) != 0);
        step();
      end
      finish_frame(10);
      checks++;
      if (got_q.size() !== exp_q.size() || fd_cnt !== 1) begin
        errors++;
        $display("FAIL rand%0d_count: got %0d transfers %0d done, required %0d/1",
                 f, got_q.size(), fd_cnt, exp_q.size());
      end else begin
        foreach (exp_q[i]) begin
          checks++;
          if (got_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL rand%0d_xfer%0d: got %h, required %h", f, i, got_q[i], exp_q[i]);
          end
        end
      end
    end
    out_ready = 1'b1;
  endtask

`ifdef SEQ_SKIP_NOP_EN
  task automatic test_skip_nop();
    logic [AW+IW-1:0] e0, e2;
    e0 = {AW'(0), 32'd5};
    e2 = {AW'(2), 32'd7};
    mem[0] = 32'd5;
    mem[1] = 32'd0;
    mem[2] = 32'd7;
    out_ready = 1'b1;
    start_frame(3);
    finish_frame(40);
    checks++;
    if (got_q.size() !== 2 || got_q[0] !== e0 || got_q[1] !== e2 || fd_cnt !== 1) begin
      errors++;
      $display("FAIL skip_nop: got %0d transfers done=%0d, required 2 (blocks 0,2) done=1",
               got_q.size(), fd_cnt);
    end
    for (int i = 0; i < 4; i++) mem[i] = '0;
    start_frame(4);
    finish_frame(40);
    checks++;
    if (valid_cycles !== 0 || fd_cnt !== 1) begin
      errors++;
      $display("FAIL skip_all_nop: got valid=%0d done=%0d, required 0/1", valid_cycles, fd_cnt);
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    enable = 1'b1;
    sample_tick = 1'b0;
    out_ready = 1'b0;
    clear_overrun = 1'b0;
    n_blocks_running = '0;
    for (int i = 0; i < int'(NB); i++) mem[i] = '0;
    test_reset();
    test_basic();
    test_stall();
    test_overrun();
    test_tick_on_last();
    test_zero_and_midchange();
    test_reset_mid();
    test_enable();
    test_random();
`ifdef SEQ_SKIP_NOP_EN
    test_skip_nop();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
